// File: rtl/state_sequencer.sv
// Instruction-sequencing FSM: fetch, decode wait, opcode-selected execute chain, halt.
// Produces the registered 6-bit state code for the control-unit decoder plus status flags.
module state_sequencer #(
    parameter int unsigned OPW         = 8,
    parameter int unsigned MEM_WAIT    = 0,
    parameter int unsigned DECODE_WAIT = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    output logic [5:0]     state,
    output logic           busy,
    output logic           halted,
    output logic           illegal,
    output logic [15:0]    instr_count
);

    localparam int unsigned WAITW = 4;
    localparam int unsigned CNTW  = 16;
    localparam int unsigned CODEW = 6;

    localparam logic [WAITW-1:0] MEM_LOAD = WAITW'(MEM_WAIT);
    localparam logic [WAITW-1:0] DEC_LOAD = WAITW'(DECODE_WAIT - 1);

    localparam logic [OPW-1:0] OP_NOP   = OPW'(8'h00);
    localparam logic [OPW-1:0] OP_CLAC  = OPW'(8'h01);
    localparam logic [OPW-1:0] OP_LDAC  = OPW'(8'h02);
    localparam logic [OPW-1:0] OP_STAC  = OPW'(8'h03);
    localparam logic [OPW-1:0] OP_MVACR = OPW'(8'h04);
    localparam logic [OPW-1:0] OP_MVRAC = OPW'(8'h05);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(8'h06);
    localparam logic [OPW-1:0] OP_MUL   = OPW'(8'h07);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(8'hFF);

    typedef enum logic [4:0] {
        PH_IDLE, PH_FETCH1, PH_FETCH2, PH_FETCH3, PH_DECODE,
        PH_CLAC, PH_LDAC1, PH_LDAC2, PH_LDAC3, PH_STAC1, PH_STAC2, PH_STAC3,
        PH_MVACR, PH_MVRAC, PH_ADD, PH_MUL, PH_HALT
    } phase_t;

    phase_t            phase, phase_next;
    logic [WAITW-1:0]  wait_cnt, wait_next;
    logic              illegal_next;
    logic [CNTW-1:0]   count_next;
    logic [CODEW-1:0]  state_next;
    logic              busy_next;
    logic              halted_next;

    // Decoder-facing code for each phase; decode wait and halt show as idle bubbles.
    function automatic logic [CODEW-1:0] code_of(input phase_t ph);
        case (ph)
            PH_FETCH1: code_of = CODEW'(1);
            PH_FETCH2: code_of = CODEW'(2);
            PH_FETCH3: code_of = CODEW'(3);
            PH_CLAC:   code_of = CODEW'(4);
            PH_LDAC1:  code_of = CODEW'(5);
            PH_LDAC2:  code_of = CODEW'(6);
            PH_LDAC3:  code_of = CODEW'(7);
            PH_STAC1:  code_of = CODEW'(8);
            PH_STAC2:  code_of = CODEW'(9);
            PH_STAC3:  code_of = CODEW'(10);
            PH_MVACR:  code_of = CODEW'(11);
            PH_MVRAC:  code_of = CODEW'(12);
            PH_ADD:    code_of = CODEW'(13);
            PH_MUL:    code_of = CODEW'(14);
            default:   code_of = CODEW'(0);
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= PH_IDLE;
            wait_cnt    <= '0;
            state       <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            phase       <= phase_next;
            wait_cnt    <= wait_next;
            state       <= state_next;
            busy        <= busy_next;
            halted      <= halted_next;
            illegal     <= illegal_next;
            instr_count <= count_next;
        end
    end

    always_comb begin
        phase_next   = phase;
        wait_next    = wait_cnt;
        illegal_next = illegal;
        count_next   = instr_count;

        case (phase)
            PH_IDLE, PH_HALT: begin
                if (start) phase_next = PH_FETCH1;
            end
            PH_FETCH1: begin
                phase_next = PH_FETCH2;
                wait_next  = MEM_LOAD;
            end
            PH_FETCH2: begin
                if (wait_cnt == '0) phase_next = PH_FETCH3;
                else                wait_next  = wait_cnt - WAITW'(1);
            end
            PH_FETCH3: begin
                phase_next = PH_DECODE;
                wait_next  = DEC_LOAD;
            end
            PH_DECODE: begin
                if (wait_cnt != '0) begin
                    wait_next = wait_cnt - WAITW'(1);
                end else begin
                    // Opcode is only looked at on this edge.
                    count_next = instr_count + CNTW'(1);
                    case (opcode)
                        OP_NOP:   phase_next = PH_FETCH1;
                        OP_CLAC:  phase_next = PH_CLAC;
                        OP_LDAC:  phase_next = PH_LDAC1;
                        OP_STAC:  phase_next = PH_STAC1;
                        OP_MVACR: phase_next = PH_MVACR;
                        OP_MVRAC: phase_next = PH_MVRAC;
                        OP_ADD:   phase_next = PH_ADD;
                        OP_MUL:   phase_next = PH_MUL;
                        OP_HALT:  phase_next = PH_HALT;
                        default: begin
                            phase_next   = PH_HALT;
                            illegal_next = 1'b1;
                            count_next   = instr_count;
                        end
                    endcase
                end
            end
            PH_LDAC1: begin
                phase_next = PH_LDAC2;
                wait_next  = MEM_LOAD;
            end
            PH_LDAC2: begin
                if (wait_cnt == '0) phase_next = PH_LDAC3;
                else                wait_next  = wait_cnt - WAITW'(1);
            end
            PH_STAC1: begin
                phase_next = PH_STAC2;
                wait_next  = MEM_LOAD;
            end
            PH_STAC2: begin
                if (wait_cnt == '0) phase_next = PH_STAC3;
                else                wait_next  = wait_cnt - WAITW'(1);
            end
            PH_CLAC, PH_LDAC3, PH_STAC3, PH_MVACR, PH_MVRAC, PH_ADD, PH_MUL: begin
                phase_next = PH_FETCH1;
            end
            default: phase_next = PH_IDLE;
        endcase

        // Outputs are registered from the next phase so they align with it.
        state_next  = code_of(phase_next);
        busy_next   = (phase_next != PH_IDLE) && (phase_next != PH_HALT);
        halted_next = (phase_next == PH_HALT);
    end

endmodule

// File: tb/tb_state_sequencer.sv
// Scoreboard bench for state_sequencer: a cycle-level expectation list is built per program
// from the instruction timing rules and consumed by an independent monitor.
module tb_state_sequencer;

    localparam int unsigned MW = 2;
    localparam int unsigned DW = 2;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [7:0]  opcode;
    logic [5:0]  state;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_count;

    state_sequencer #(.OPW(8), .MEM_WAIT(MW), .DECODE_WAIT(DW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
        .state(state), .busy(busy), .halted(halted), .illegal(illegal),
        .instr_count(instr_count)
    );

    typedef struct {
        logic [5:0]  st;
        logic        busy;
        logic        halted;
        logic        illegal;
        logic [15:0] cnt;
        logic        opv;
        logic [7:0]  op;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  prog[$];
    logic [15:0] m_count;
    logic        m_ill;
    logic        pend_v;
    logic [7:0]  pend_op;
    int          tests;
    int          fails;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    // One expected cycle; a pending opcode is attached to the first cycle after its decode edge.
    task automatic add(input int st, input bit b, input bit h);
        exp_t e;
        e.st = 6'(st); e.busy = b; e.halted = h; e.illegal = m_ill; e.cnt = m_count;
        e.opv = pend_v; e.op = pend_op;
        pend_v = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_front_end();
        add(1, 1, 0);
        repeat (1 + MW) add(2, 1, 0);
        add(3, 1, 0);
        repeat (DW) add(0, 1, 0);
    endtask

    task automatic push_instr(input logic [7:0] op);
        push_front_end();
        pend_v = 1'b1;
        pend_op = op;
        if (op <= 8'h07 || op == 8'hFF) m_count = m_count + 16'd1;
        case (op)
            8'h00: ;
            8'h01: add(4, 1, 0);
            8'h02: begin add(5, 1, 0); repeat (1 + MW) add(6, 1, 0); add(7, 1, 0); end
            8'h03: begin add(8, 1, 0); repeat (1 + MW) add(9, 1, 0); add(10, 1, 0); end
            8'h04, 8'h05, 8'h06, 8'h07: add(11 + int'(op) - 4, 1, 0);
            8'hFF: add(0, 0, 1);
            default: begin m_ill = 1'b1; add(0, 0, 1); end
        endcase
    endtask

    task automatic set_op();
        if (q.size() > 0 && q[0].opv) opcode = q[0].op;
        else                          opcode = 8'($urandom);
    endtask

    // Called at a negedge with the DUT idle or halted; start is random while it must be ignored.
    task automatic run_loop(input int k);
        int cyc;
        cyc = 0;
        start = 1'b1;
        set_op();
        forever begin
            @(negedge clock);
            cyc++;
            if (q.size() == 0) break;
            if (cyc > 3000) begin
                tests++; fails++;
                $display("FAIL timeout: %0d expected cycles left", q.size());
                q.delete();
                break;
            end
            start = (q.size() > k) ? 1'($urandom) : 1'b0;
            set_op();
        end
        start = 1'b0;
    endtask

    task automatic run_prog(input int k);
        foreach (prog[i]) push_instr(prog[i]);
        repeat (k) add(0, 0, 1);
        prog.delete();
        run_loop(k);
    endtask

    // Monitor: compares each produced cycle against the head of the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("state",       16'(state),  16'(e.st));
                check("busy",        16'(busy),   16'(e.busy));
                check("halted",      16'(halted), 16'(e.halted));
                check("illegal",     16'(illegal), 16'(e.illegal));
                check("instr_count", instr_count, e.cnt);
            end
        end
    end

    initial begin
        tests = 0; fails = 0;
        m_count = '0; m_ill = 1'b0; pend_v = 1'b0; pend_op = '0;
        reset_n = 1'b0; start = 1'b0; opcode = '0;
        repeat (2) @(negedge clock);
        check("rst_state",   16'(state),   16'd0);
        check("rst_busy",    16'(busy),    16'd0);
        check("rst_halted",  16'(halted),  16'd0);
        check("rst_illegal", 16'(illegal), 16'd0);
        check("rst_count",   instr_count,  16'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // clac then halt, halt held for 10 cycles
        prog.push_back(8'h01); prog.push_back(8'hFF);
        run_prog(10);
        // ldac with held memory phases
        prog.push_back(8'h02); prog.push_back(8'hFF);
        run_prog(2);
        // illegal opcode, then resume with illegal still set
        prog.push_back(8'h03); prog.push_back(8'h3C);
        run_prog(3);
        prog.push_back(8'h06); prog.push_back(8'hFF);
        run_prog(1);

        // instr_count wrap
        force dut.instr_count = 16'hFFFF;
        @(negedge clock);
        release dut.instr_count;
        m_count = 16'hFFFF;
        prog.push_back(8'h00); prog.push_back(8'hFF);
        run_prog(1);

        // reset in the middle of stac2, then restart from idle
        push_front_end();
        pend_v = 1'b1; pend_op = 8'h03;
        m_count = m_count + 16'd1;
        add(8, 1, 0);
        add(9, 1, 0);
        run_loop(0);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state",   16'(state),   16'd0);
        check("arst_busy",    16'(busy),    16'd0);
        check("arst_halted",  16'(halted),  16'd0);
        check("arst_illegal", 16'(illegal), 16'd0);
        check("arst_count",   instr_count,  16'd0);
        m_count = '0; m_ill = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        prog.push_back(8'h05); prog.push_back(8'hFF);
        run_prog(0);

        // random programs
        for (int p = 0; p < 25; p++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) prog.push_back(8'($urandom_range(0, 7)));
            if ($urandom_range(0, 5) == 0) prog.push_back(8'($urandom_range(8, 254)));
            else                           prog.push_back(8'hFF);
            run_prog($urandom_range(0, 4));
        end

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
